// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: opcodes, functs,
// ALU operations, state codes, mux select codes and the per-state control bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic SRCA_PC  = 1'b0;
    localparam logic SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    // Moore control bundle for a state; ex_op is the funct-decoded ALU operation.
    function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] ex_op);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_src    = PC_ALU;
            end
            S_DECODE:  c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ex_op;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PC_ALUOUT;
            end
            S_ADDIEX: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB:  c.reg_write = 1'b1;
            S_JUMP:    c.pc_src    = PC_JUMP;
            default:   c.alu_op    = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU operation decoder; funct_valid flags the supported subset.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       funct_valid
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        alu_op      = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM with memory wait-limit abort.
// Optional macro MIPS_CTRL_BNE_EN adds bne decoding to the BRANCH state.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255,
    parameter int WAIT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (MEM_WAIT_MAX == 0) ? '0 : WAIT_W'(MEM_WAIT_MAX - 1);

    state_t            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              illegal_q, timeout_q;
    logic [2:0]        ex_alu_op;
    logic              funct_valid, op_legal, is_bne, take_branch;
    logic              mem_done, waiting, limit_hit, access_entry;

    mips_alu_decoder u_alu_dec (
        .funct       (funct),
        .alu_op      (ex_alu_op),
        .funct_valid (funct_valid)
    );

`ifdef MIPS_CTRL_BNE_EN
    assign is_bne = (opcode == OP_BNE);
`else
    assign is_bne = 1'b0;
`endif

    assign take_branch = is_bne ? ~zero_flag : zero_flag;

    // NOTE: the FETCH bundle resets with mem_req set, so reset gates it combinationally.
    assign mem_req  = ctrl_q.mem_req & rst_n;
    assign mem_done = mem_req & mem_ready;
    assign waiting  = mem_req & ~mem_ready;
    assign limit_hit = (MEM_WAIT_MAX != 0) && waiting && (wait_cnt == WAIT_LAST);

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            OP_RTYPE: op_legal = funct_valid;
            default:  op_legal = is_bne;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal) state_d = S_FETCH;
                else begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_BRANCH;
                    endcase
                end
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_done) state_d = S_MEMWB;
            S_MEMWR:   if (mem_done) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
        if (limit_hit) state_d = S_FETCH;

        // Outputs are registered from the next state; an abort lands in FETCH with the request dropped.
        ctrl_d = state_ctrl(state_d, ex_alu_op);
        if (limit_hit) ctrl_d.mem_req = 1'b0;

        access_entry = limit_hit ||
                       ((state_d != state_q) &&
                        (state_d == S_FETCH || state_d == S_MEMRD || state_d == S_MEMWR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH, ALU_ADD);
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= (state_q == S_DECODE) && !op_legal;
            timeout_q <= limit_hit;
            if (access_entry)                   wait_cnt <= '0;
            else if (waiting && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign ir_write    = (state_q == S_FETCH) && mem_done;
    assign pc_en       = ir_write || (state_q == S_JUMP) || ((state_q == S_BRANCH) && take_branch);
    assign mem_write   = ctrl_q.mem_write;
    assign iord        = ctrl_q.iord;
    assign pc_src      = ctrl_q.pc_src;
    assign alu_src_a   = ctrl_q.alu_src_a;
    assign alu_src_b   = ctrl_q.alu_src_b;
    assign alu_op      = ctrl_q.alu_op;
    assign reg_write   = ctrl_q.reg_write;
    assign reg_dst     = ctrl_q.reg_dst;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: an instruction-level model queues the expected
// per-cycle control word; a monitor compares at each falling edge. Honors MIPS_CTRL_BNE_EN.
module tb_mips_mc_control;

    localparam int WMAX = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_write, iord, ir_write, pc_en;
        logic [1:0] pc_src;
        logic       a;
        logic [1:0] b;
        logic [2:0] op;
        logic       reg_write, reg_dst, mem_to_reg, illegal, timeout;
    } obs_t;

    logic       clk, rst_n;
    logic [5:0] opcode, funct;
    logic       zero_flag, mem_ready;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op, mem_timeout;
    logic [2:0] alu_op;
    logic [3:0] state;

    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    bit   sb_on  = 0;
    bit   pend_illegal = 0;
    obs_t exp_q[$];

    mips_mc_control #(.MEM_WAIT_MAX(WMAX), .WAIT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero_flag(zero_flag), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Spec-listed outputs of each phase of an instruction (pulses and Mealy strobes added by callers).
    function automatic obs_t phase(input int st);
        obs_t e;
        e    = '0;
        e.st = 4'(st);
        e.op = 3'b010;
        case (st)
            0:  begin e.mem_req = 1; e.b = 2'b01; end
            1:  e.b = 2'b11;
            2:  begin e.a = 1; e.b = 2'b10; end
            3:  begin e.mem_req = 1; e.iord = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            5:  begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; end
            6:  e.a = 1;
            7:  begin e.reg_write = 1; e.reg_dst = 1; end
            8:  begin e.a = 1; e.op = 3'b110; e.pc_src = 2'b01; end
            9:  begin e.a = 1; e.b = 2'b10; end
            10: e.reg_write = 1;
            11: begin e.pc_src = 2'b10; e.pc_en = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic int alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 12) return 0;
        if (r < 18) return int'($urandom_range(1, 3));
        return int'($urandom_range(WMAX, WMAX + 2));
    endfunction

    // One clock cycle of stimulus with its expected control word.
    task automatic cyc(input bit rdy, input bit z, input obs_t e_in);
        obs_t e;
        e = e_in;
        if (pend_illegal) begin
            e.illegal    = 1'b1;
            pend_illegal = 1'b0;
        end
        mem_ready = rdy;
        zero_flag = z;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // A memory access held for `waits` not-ready cycles; WMAX or more ends in a timeout abort.
    task automatic mem_access(input int st, input int waits, output bit aborted);
        obs_t e;
        int   n;
        n = (waits >= WMAX) ? WMAX : waits;
        for (int i = 0; i < n; i++) cyc(1'b0, rbit(), phase(st));
        if (waits >= WMAX) begin
            aborted   = 1'b1;
            e         = phase(0);
            e.mem_req = 1'b0;
            e.timeout = 1'b1;
            cyc(rbit(), rbit(), e);
        end else begin
            aborted = 1'b0;
            e       = phase(st);
            if (st == 0) begin
                e.ir_write = 1'b1;
                e.pc_en    = 1'b1;
            end
            cyc(1'b1, rbit(), e);
        end
    endtask

    task automatic branch_cycle(input bit z, input bit take);
        obs_t e;
        e       = phase(8);
        e.pc_en = take;
        cyc(rbit(), z, e);
    endtask

    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                             input int fw, input int dw, input bit z);
        bit   ab;
        obs_t e;
        int   code;
        opcode = opc;
        funct  = fn;
        mem_access(0, fw, ab);
        while (ab) mem_access(0, int'($urandom_range(0, 2)), ab);
        cyc(rbit(), rbit(), phase(1));
        case (opc)
            6'b000000: begin
                code = alu_of(fn);
                if (code < 0) pend_illegal = 1'b1;
                else begin
                    e    = phase(6);
                    e.op = 3'(code);
                    cyc(rbit(), rbit(), e);
                    cyc(rbit(), rbit(), phase(7));
                end
            end
            6'b100011: begin
                cyc(rbit(), rbit(), phase(2));
                mem_access(3, dw, ab);
                if (!ab) cyc(rbit(), rbit(), phase(4));
            end
            6'b101011: begin
                cyc(rbit(), rbit(), phase(2));
                mem_access(5, dw, ab);
            end
            6'b000100: branch_cycle(z, z);
`ifdef MIPS_CTRL_BNE_EN
            6'b000101: branch_cycle(z, !z);
`endif
            6'b001000: begin
                cyc(rbit(), rbit(), phase(9));
                cyc(rbit(), rbit(), phase(10));
            end
            6'b000010: cyc(rbit(), rbit(), phase(11));
            default:   pend_illegal = 1'b1;
        endcase
    endtask

    always @(negedge clk) begin
        if (sb_on) begin
            cyc_n++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard cycle %0d: DUT state %0d with no expected entry", cyc_n, state);
            end else begin
                obs_t got, exp;
                got = '{state, mem_req, mem_write, iord, ir_write, pc_en, pc_src,
                        alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                        illegal_op, mem_timeout};
                exp = exp_q.pop_front();
                check($sformatf("cycle %0d ctrl", cyc_n), 32'(got), 32'(exp));
            end
        end
    end

    initial begin
        logic [5:0] opc, fn;
        int         k;
        rst_n = 1'b0; opcode = '0; funct = '0; zero_flag = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset strobes", 32'({mem_req, mem_write, ir_write, pc_en, reg_write,
                                    illegal_op, mem_timeout}), 32'd0);
        rst_n = 1'b1;
        sb_on = 1'b1;

        run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);   // add, all ready
        run_instr(6'b100011, 6'b000000, 0, 3, 1'b0);   // lw, 3 waits in MEMRD
        run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);   // beq taken
        run_instr(6'b000100, 6'b000000, 0, 0, 1'b0);   // beq not taken
        run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);   // illegal opcode
        run_instr(6'b000000, 6'b000111, 0, 0, 1'b0);   // illegal funct
        run_instr(6'b101011, 6'b000000, 0, 6, 1'b0);   // sw wait-limit abort
        run_instr(6'b000101, 6'b000000, 0, 0, 1'b0);   // bne, zero clear
        run_instr(6'b000010, 6'b000000, 5, 0, 1'b0);   // j after a fetch timeout

        for (int n = 0; n < 300; n++) begin
            k  = int'($urandom_range(0, 9));
            fn = 6'($urandom);
            case (k)
                0, 1: begin
                    opc = 6'b000000;
                    if ($urandom_range(0, 4) != 0) begin
                        case ($urandom_range(0, 4))
                            0: fn = 6'b100000;
                            1: fn = 6'b100010;
                            2: fn = 6'b100100;
                            3: fn = 6'b100101;
                            default: fn = 6'b101010;
                        endcase
                    end
                end
                2, 9: opc = 6'b100011;
                3: opc = 6'b101011;
                4: opc = 6'b000100;
                5: opc = 6'b000101;
                6: opc = 6'b001000;
                7: opc = 6'b000010;
                default: opc = 6'($urandom);
            endcase
            run_instr(opc, fn, rand_wait(), rand_wait(), rbit());
        end
        run_instr(6'b001000, 6'b000000, 0, 0, 1'b0);

        // Reset asserted while a store is waiting in MEMWR.
        opcode = 6'b101011;
        cyc(1'b1, 1'b0, '{st: 4'd0, mem_req: 1, ir_write: 1, pc_en: 1, b: 2'b01, op: 3'b010, default: '0});
        cyc(1'b0, 1'b0, phase(1));
        cyc(1'b0, 1'b0, phase(2));
        cyc(1'b0, 1'b0, phase(5));
        cyc(1'b0, 1'b0, phase(5));
        sb_on     = 1'b0;
        mem_ready = 1'b0;
        #2;
        check("pre-reset MEMWR", 32'({state, mem_req, mem_write}), 32'({4'd5, 1'b1, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("mid-access reset state", 32'(state), 32'd0);
        check("mid-access reset strobes", 32'({mem_req, mem_write, ir_write, pc_en, reg_write,
                                               illegal_op, mem_timeout}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_on = 1'b1;
        run_instr(6'b000000, 6'b101010, 0, 0, 1'b0);
        run_instr(6'b001000, 6'b000000, 1, 0, 1'b0);
        sb_on = 1'b0;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
